// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 mouse tracker: status-byte bit indices,
// packet-framing FSM state encoding, packet-length constants and the
// delta saturation helper.
package ps2_pkg;

    // Status byte (byte 0) bit positions
    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_M   = 2;
    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;
    localparam int XOVF    = 6;
    localparam int YOVF    = 7;

    // Packet framing states; WAIT_B3 only used for wheel (4-byte) packets
    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        WAIT_B3 = 2'd3
    } ps2_state_t;

    localparam int PKT_LEN_STD   = 3;
    localparam int PKT_LEN_WHEEL = 4;

    function automatic int pkt_len(input bit wheel_en);
        return wheel_en ? PKT_LEN_WHEEL : PKT_LEN_STD;
    endfunction

    // 9-bit signed delta from sign bit + magnitude byte; overflow pins it
    // to the extreme of the direction given by the sign bit.
    function automatic logic signed [8:0] sat_delta(input logic       sign_b,
                                                    input logic       ovf_b,
                                                    input logic [7:0] mag);
        if (ovf_b)
            return sign_b ? 9'sh100 : 9'sh0FF;
        return $signed({sign_b, mag});
    endfunction

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// ps2_mouse_tracker_if
// Byte stream from ps2_receiver into the mouse tracker.
//   rx_data  : received byte, valid while rx_ready is high
//   rx_ready : one-cycle strobe per received byte
//   rx_error : one-cycle strobe, parity/framing error on the current byte
// master = receiver side (drives), slave = tracker side (samples).
interface ps2_mouse_tracker_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;

    modport master (output rx_data, output rx_ready, output rx_error);
    modport slave  (input  rx_data, input  rx_ready, input  rx_error);
endinterface

// File: rtl/ps2_clamp_add.sv
// ps2_clamp_add
// Adds a signed delta to an unsigned position and saturates the result
// to [0, LIMIT-1]. Purely combinational; one instance per axis.
//   pos   : current position (unsigned, POS_W bits)
//   delta : signed step, POS_W+2 bits
//   sum   : clamped new position
module ps2_clamp_add #(
    parameter int POS_W = 10,
    parameter int LIMIT = 640
) (
    input  logic [POS_W-1:0]        pos,
    input  logic signed [POS_W+1:0] delta,
    output logic [POS_W-1:0]        sum
);

    localparam logic signed [POS_W+1:0] MAX_S = (POS_W+2)'(LIMIT - 1);

    logic signed [POS_W+1:0] raw;

    always_comb begin
        raw = $signed({2'b00, pos}) + delta;
        if (raw[POS_W+1])
            sum = '0;
        else if (raw > MAX_S)
            sum = MAX_S[POS_W-1:0];
        else
            sum = raw[POS_W-1:0];
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
// Frames PS/2 mouse packets (3-byte standard or 4-byte wheel) from the
// receiver byte stream, recovers from desync/timeout/parity errors, and
// keeps a clamped absolute cursor position.
//   clk, rst  : system clock, synchronous active-high reset
//   rx        : byte stream from ps2_receiver (slave modport)
//   recenter  : one-cycle request to move the cursor to canvas centre
//   pos_x/y   : cursor position
//   buttons   : {M,R,L} from last good packet
//   dx/dy     : last decoded delta (saturated, unscaled)
//   wheel     : last Z value (0 when WHEEL_EN=0)
//   pkt_valid : pulse per good packet
//   sync_err  : pulse per discarded byte or packet
//   ovf       : pulse with pkt_valid when an overflow bit was set
module ps2_mouse_tracker
    import ps2_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int POS_W       = 10,
    parameter int WHEEL_EN    = 0,
    parameter int TIMEOUT_CYC = 27000,
    parameter int SCALE_SHIFT = 0,
    parameter int INVERT_Y    = 1
) (
    input  logic                clk,
    input  logic                rst,
    ps2_mouse_tracker_if.slave  rx,
    input  logic                recenter,
    output logic [POS_W-1:0]    pos_x,
    output logic [POS_W-1:0]    pos_y,
    output logic [2:0]          buttons,
    output logic signed [8:0]   dx,
    output logic signed [8:0]   dy,
    output logic signed [3:0]   wheel,
    output logic                pkt_valid,
    output logic                sync_err,
    output logic                ovf
);

    localparam int PKT_LEN = pkt_len(WHEEL_EN != 0);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [POS_W-1:0] CENTRE_X = POS_W'(SCREEN_W / 2);
    localparam logic [POS_W-1:0] CENTRE_Y = POS_W'(SCREEN_H / 2);

    ps2_state_t      state;
    logic [TO_W-1:0] to_cnt;

    // Latched packet fields
    logic [2:0] s_btn;
    logic       s_xs, s_ys, s_xo, s_yo;
    logic [7:0] x_q;
    logic [7:0] y_q;

    logic                    byte_ok;
    logic                    commit;
    logic [7:0]              y_src;
    logic signed [8:0]       dx_new, dy_new;
    logic signed [8:0]       sdx, sdy;
    logic signed [POS_W+1:0] dx_ext, dy_ext, dy_step;
    logic [POS_W-1:0]        pos_x_nxt, pos_y_nxt;

    assign byte_ok = rx.rx_ready & ~rx.rx_error;

    // The commit cycle for 3-byte packets is the Y byte itself, so Y comes
    // straight from the bus; for 4-byte packets it was latched in WAIT_B2.
    assign commit = byte_ok &
                    (((state == WAIT_B2) && (PKT_LEN == PKT_LEN_STD)) ||
                      (state == WAIT_B3));

    always_comb begin
        y_src   = (state == WAIT_B3) ? y_q : rx.rx_data;
        dx_new  = sat_delta(s_xs, s_xo, x_q);
        dy_new  = sat_delta(s_ys, s_yo, y_src);
        sdx     = dx_new >>> SCALE_SHIFT;
        sdy     = dy_new >>> SCALE_SHIFT;
        dx_ext  = {{(POS_W-7){sdx[8]}}, sdx};
        dy_ext  = {{(POS_W-7){sdy[8]}}, sdy};
        dy_step = (INVERT_Y != 0) ? -dy_ext : dy_ext;
    end

    ps2_clamp_add #(.POS_W(POS_W), .LIMIT(SCREEN_W)) u_clamp_x (
        .pos   (pos_x),
        .delta (dx_ext),
        .sum   (pos_x_nxt)
    );

    ps2_clamp_add #(.POS_W(POS_W), .LIMIT(SCREEN_H)) u_clamp_y (
        .pos   (pos_y),
        .delta (dy_step),
        .sum   (pos_y_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_B0;
            to_cnt    <= '0;
            s_btn     <= '0;
            s_xs      <= 1'b0;
            s_ys      <= 1'b0;
            s_xo      <= 1'b0;
            s_yo      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pos_x     <= CENTRE_X;
            pos_y     <= CENTRE_Y;
            buttons   <= '0;
            dx        <= '0;
            dy        <= '0;
            wheel     <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            ovf       <= 1'b0;

            if (rx.rx_error) begin
                state    <= WAIT_B0;
                to_cnt   <= '0;
                sync_err <= 1'b1;
            end else if (rx.rx_ready) begin
                to_cnt <= '0;
                case (state)
                    WAIT_B0: begin
                        if (rx.rx_data[ALWAYS1]) begin
                            s_btn <= rx.rx_data[BTN_M:BTN_L];
                            s_xs  <= rx.rx_data[XSIGN];
                            s_ys  <= rx.rx_data[YSIGN];
                            s_xo  <= rx.rx_data[XOVF];
                            s_yo  <= rx.rx_data[YOVF];
                            state <= WAIT_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    WAIT_B1: begin
                        x_q   <= rx.rx_data;
                        state <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        if (PKT_LEN == PKT_LEN_WHEEL) begin
                            y_q   <= rx.rx_data;
                            state <= WAIT_B3;
                        end else begin
                            state <= WAIT_B0;
                        end
                    end
                    default: state <= WAIT_B0;
                endcase
            end else if (state != WAIT_B0) begin
                // A byte arriving on the expiry cycle still counts as accepted
                if (to_cnt == TO_MAX) begin
                    state    <= WAIT_B0;
                    to_cnt   <= '0;
                    sync_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end

            if (commit) begin
                buttons   <= s_btn;
                dx        <= dx_new;
                dy        <= dy_new;
                pos_x     <= pos_x_nxt;
                pos_y     <= pos_y_nxt;
                pkt_valid <= 1'b1;
                ovf       <= s_xo | s_yo;
                if (PKT_LEN == PKT_LEN_WHEEL)
                    wheel <= $signed(rx.rx_data[3:0]);
            end

            // Recenter overrides any commit position update in the same cycle
            if (recenter) begin
                pos_x <= CENTRE_X;
                pos_y <= CENTRE_Y;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker
// Directed-vector bench for ps2_mouse_tracker: a default-parameter
// instance and a wheel/scaled instance, each fed by its own interface.
module tb_ps2_mouse_tracker;

    localparam int T_M = 27000;
    localparam int T_W = 100;

    logic clk = 1'b0;
    logic rst;
    logic rc_m, rc_w;

    always #5 clk = ~clk;

    ps2_mouse_tracker_if rx_m ();
    ps2_mouse_tracker_if rx_w ();

    logic [9:0]        m_pos_x, m_pos_y, w_pos_x, w_pos_y;
    logic [2:0]        m_buttons, w_buttons;
    logic signed [8:0] m_dx, m_dy, w_dx, w_dy;
    logic signed [3:0] m_wheel, w_wheel;
    logic              m_pkt, m_serr, m_ovf, w_pkt, w_serr, w_ovf;

    ps2_mouse_tracker #(
        .SCREEN_W(640), .SCREEN_H(480), .POS_W(10), .WHEEL_EN(0),
        .TIMEOUT_CYC(T_M), .SCALE_SHIFT(0), .INVERT_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx_m.slave), .recenter(rc_m),
        .pos_x(m_pos_x), .pos_y(m_pos_y), .buttons(m_buttons),
        .dx(m_dx), .dy(m_dy), .wheel(m_wheel),
        .pkt_valid(m_pkt), .sync_err(m_serr), .ovf(m_ovf)
    );

    ps2_mouse_tracker #(
        .SCREEN_W(640), .SCREEN_H(480), .POS_W(10), .WHEEL_EN(1),
        .TIMEOUT_CYC(T_W), .SCALE_SHIFT(1), .INVERT_Y(1)
    ) dut_w (
        .clk(clk), .rst(rst), .rx(rx_w.slave), .recenter(rc_w),
        .pos_x(w_pos_x), .pos_y(w_pos_y), .buttons(w_buttons),
        .dx(w_dx), .dy(w_dy), .wheel(w_wheel),
        .pkt_valid(w_pkt), .sync_err(w_serr), .ovf(w_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic idle_bus();
        rx_m.rx_data = 8'h00; rx_m.rx_ready = 1'b0; rx_m.rx_error = 1'b0;
        rx_w.rx_data = 8'h00; rx_w.rx_ready = 1'b0; rx_w.rx_error = 1'b0;
        rc_m = 1'b0; rc_w = 1'b0;
    endtask

    // One-cycle byte strobe; returns on the negedge after the capture edge
    task automatic send(input bit w, input logic [7:0] d, input bit rc = 1'b0);
        @(negedge clk);
        if (w) begin
            rx_w.rx_data = d; rx_w.rx_ready = 1'b1; rc_w = rc;
        end else begin
            rx_m.rx_data = d; rx_m.rx_ready = 1'b1; rc_m = rc;
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic err_strobe(input bit with_ready, input logic [7:0] d);
        @(negedge clk);
        rx_m.rx_error = 1'b1;
        rx_m.rx_ready = with_ready;
        rx_m.rx_data  = d;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(1'b0, b0);
        send(1'b0, b1);
        send(1'b0, b2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_pos_x", m_pos_x, 320);
        check("rst_pos_y", m_pos_y, 240);
        check("rst_buttons", m_buttons, 0);
        check("rst_pulses", {m_pkt, m_serr, m_ovf}, 0);
        check("rst_dx", m_dx, 0);

        // Basic packet
        send3(8'h09, 8'h05, 8'h05);
        check("p1_pkt_valid", m_pkt, 1);
        check("p1_pos_x", m_pos_x, 325);
        check("p1_pos_y", m_pos_y, 235);
        check("p1_buttons", m_buttons, 1);
        check("p1_dx", m_dx, 5);
        @(negedge clk);
        check("p1_pkt_one_cycle", m_pkt, 0);

        // Desync byte then negative packet
        send(1'b0, 8'h00);
        check("desync_serr", m_serr, 1);
        send3(8'h38, 8'hF9, 8'hF9);
        check("neg_dx", m_dx, -7);
        check("neg_dy", m_dy, -7);
        check("neg_pos_x", m_pos_x, 318);
        check("neg_pos_y", m_pos_y, 242);
        check("neg_serr_clear", m_serr, 0);

        // Clamp at high X and low Y
        send3(8'h08, 8'hFF, 8'h00);
        send3(8'h08, 8'h3E, 8'h00);
        check("pre_clamp_x", m_pos_x, 635);
        send3(8'h08, 8'h14, 8'h00);
        check("clamp_x_max", m_pos_x, 639);
        send3(8'h08, 8'h00, 8'hF0);
        check("pre_clamp_y", m_pos_y, 2);
        send3(8'h08, 8'h00, 8'h0A);
        check("clamp_y_min", m_pos_y, 0);

        // Mid-packet timeout
        send(1'b0, 8'h08);
        send(1'b0, 8'h05);
        cyc = 0;
        while (!m_serr && cyc < T_M + 5) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_latency", cyc, T_M + 1);
        check("timeout_pos_x", m_pos_x, 639);
        check("timeout_pos_y", m_pos_y, 0);

        // Parity error after byte 1, then clean packet
        send(1'b0, 8'h08);
        err_strobe(1'b0, 8'h00);
        check("rxerr_serr", m_serr, 1);
        send3(8'h0A, 8'h00, 8'h00);
        check("after_err_pkt", m_pkt, 1);
        check("after_err_buttons", m_buttons, 2);

        // Error and ready together: error wins, byte dropped
        send(1'b0, 8'h08);
        err_strobe(1'b1, 8'h10);
        check("err_wins_serr", m_serr, 1);
        send3(8'h1C, 8'hFF, 8'h00);
        check("err_wins_buttons", m_buttons, 4);
        check("err_wins_pos_x", m_pos_x, 638);

        // Overflow saturation
        send3(8'h48, 8'h00, 8'h00);
        check("ovf_pos_dx", m_dx, 255);
        check("ovf_pulse", m_ovf, 1);
        check("ovf_pos_x", m_pos_x, 639);
        @(negedge clk);
        check("ovf_one_cycle", m_ovf, 0);
        send3(8'h58, 8'h00, 8'h00);
        check("ovf_neg_dx", m_dx, -256);
        check("ovf_neg_pos_x", m_pos_x, 383);

        // Recenter coincident with commit
        send(1'b0, 8'h09);
        send(1'b0, 8'h10);
        send(1'b0, 8'h10, 1'b1);
        check("rc_pos_x", m_pos_x, 320);
        check("rc_pos_y", m_pos_y, 240);
        check("rc_buttons", m_buttons, 1);
        check("rc_dx", m_dx, 16);
        check("rc_pkt", m_pkt, 1);

        // Reset mid-packet discards partial bytes
        send(1'b0, 8'h08);
        send(1'b0, 8'h05);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_buttons", m_buttons, 0);
        check("midrst_dx", m_dx, 0);
        send3(8'h09, 8'h01, 8'h01);
        check("midrst_pos_x", m_pos_x, 321);
        check("midrst_pos_y", m_pos_y, 239);
        check("no_wheel", m_wheel, 0);

        // Wheel instance: 4-byte framing
        send(1'b1, 8'h08);
        send(1'b1, 8'h00);
        send(1'b1, 8'h00);
        check("w_no_pkt_b2", w_pkt, 0);
        send(1'b1, 8'h0F);
        check("w_pkt", w_pkt, 1);
        check("w_wheel", w_wheel, -1);
        @(negedge clk);
        check("w_pkt_one_cycle", w_pkt, 0);

        // Scaled negative delta rounds toward minus infinity
        send(1'b1, 8'h18);
        send(1'b1, 8'hFD);
        send(1'b1, 8'h00);
        send(1'b1, 8'h00);
        check("w_dx", w_dx, -3);
        check("w_pos_x", w_pos_x, 318);
        check("w_pos_y", w_pos_y, 240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
